apb_arb_master: RTL and testbench
=================================

# apb_arb_master

Two-requester APB master with round-robin arbitration. It lets two independent command sources share one APB bus to the register slave. It accepts a held request/command from each requester and grants the bus to one of them. It then runs the APB SETUP/ACCESS sequence, waits on PREADY with a bounded timeout, and returns read data plus a one-cycle completion pulse to the granted requester. It sits between the command sources and the existing APB slave/register path, in place of the single-source master.

## Interface
- ADDR_W, 32, PADDR and requester address width
- DATA_W, 32, PWDATA/PRDATA and requester data width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort (≥2)
- PCLK  in  1  clock, all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req0, req1  in  1  request; held high with command fields stable until matching done
- wr0, wr1  in  1  1=write, 0=read
- addr0, addr1  in  ADDR_W  transfer address
- wdata0, wdata1  in  DATA_W  write data
- done0, done1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle timeout flag, coincident with done
- rdata0, rdata1  out  DATA_W  read data, valid while done high, held until next done on that port
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PREADY  in  1; PRDATA  in  DATA_W

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset → IDLE.
- IDLE: compute eligible requests. reqN is masked in a cycle where doneN is high. No eligible request → stay. One eligible → grant it. Both eligible → grant the requester not in last_grant. Latch grant, wr, addr, wdata into PWRITE/PADDR/PWDATA. Set PSEL=1. → SETUP.
- SETUP: PSEL=1, PENABLE=1 next → ACCESS. Clear wait counter.
- ACCESS with PREADY=1: complete. PSEL=0, PENABLE=0. done<grant>=1. For a read, rdata<grant>=PRDATA; for a write, rdata unchanged. last_grant=grant. → IDLE.
- ACCESS with PREADY=0: increment wait counter. When the counter equals TIMEOUT-1 and PREADY is still 0, abort. Abort drops PSEL/PENABLE, pulses done<grant> and err<grant>, forces rdata<grant>=0 for reads, updates last_grant, and goes → IDLE.
- last_grant resets to 1, so requester 0 wins the first simultaneous contest.
- PADDR/PWRITE/PWDATA hold their latched values from IDLE exit until the next grant. They are not cleared at completion.
- All outputs are registered. Reset value of every output is 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, done*, err*, rdata*.
- Reset mid-transfer: bus controls drop asynchronously, no done/err is issued, FSM → IDLE, and the requester's command is discarded.
- A req dropped before done is a protocol violation. The in-flight transfer still completes and its done is still issued.
- Wait counter width is clog2(TIMEOUT), and it never wraps.

## Timing
- Edge numbering: e0 is the edge where IDLE sees req. After e0, SETUP. After e1, ACCESS. At e2, PREADY=1 is sampled. After e2, done is high for one cycle and the FSM is in IDLE.
- Zero-wait transfer takes 3 cycles from request to done. Each PREADY-low ACCESS cycle adds one cycle.
- Back-to-back: after done, the next grant is issued at the following IDLE edge. A queued other requester gets SETUP in the cycle after done.
- Minimum bus turnaround: one cycle with PSEL=0 between transfers.
- Timeout: the abort edge is the TIMEOUT-th ACCESS edge with PREADY low. err/done are high for one cycle after it.
- PENABLE is never high without PSEL. PSEL rises exactly one cycle before PENABLE.

## Test plan
- Reset, then single write from requester 0: addr0=0x10, wdata0=0xDEADBEEF, PREADY tied 1 → PSEL cycle, then PSEL+PENABLE with PWRITE=1 and PADDR=0x10; done0 after 3 cycles; err0=0; done1 never.
- Read from requester 1: addr1=0x10, PRDATA=0xDEADBEEF, PREADY low for 2 ACCESS cycles → done1 5 cycles after request; rdata1=0xDEADBEEF; rdata0 unchanged.
- Both request simultaneously after reset, continuously held → grant order 0,1,0,1. Each done matches its own address/data. One idle PSEL=0 cycle separates transfers.
- Timeout with TIMEOUT=4: read from requester 0, PREADY held 0 → done0 and err0 together after the 4th ACCESS cycle; rdata0=0; bus returns to IDLE; a subsequent requester 1 transfer completes normally.
- PRESETn asserted in ACCESS with PREADY low → PSEL/PENABLE 0 immediately, no done/err. After release, a held req0 starts a fresh transfer.
- Requester 0 re-requests immediately after done0 while req1 is pending → requester 1 is granted next, and requester 0 is not granted twice.

Source files
------------

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between the arbitrating master and the register slave.
//   PSEL, PENABLE, PWRITE : transfer controls, driven by the master
//   PADDR, PWDATA         : latched address / write data, driven by the master
//   PREADY, PRDATA        : slave handshake and read data, driven by the slave
interface apb_arb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA
  );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester APB master with round-robin arbitration and a bounded
// PREADY timeout.
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   reqN/wrN/addrN/wdataN  : held command from requester N (N = 0, 1)
//   doneN                  : one-cycle completion pulse to requester N
//   errN                   : one-cycle timeout flag, coincident with doneN
//   rdataN                 : read data, held until the next doneN
//   apb                    : APB master side (PSEL/PENABLE/PWRITE/PADDR/PWDATA
//                            out, PREADY/PRDATA in)
module apb_arb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  apb_arb_master_if.master  apb
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              elig0, elig1, pick;
  logic              timeout_hit, xfer_end;
  logic [DATA_W-1:0] rd_val;

  // A requester is ignored in its own done cycle so a still-held req is not
  // mistaken for a new command.
  assign elig0 = req0 & ~done0_q;
  assign elig1 = req1 & ~done1_q;
  // Contest goes to the requester that was not served last.
  assign pick  = (elig0 & elig1) ? ~last_grant_q : elig1;

  assign timeout_hit = ~apb.PREADY & (wait_cnt_q == CNT_LAST);
  assign xfer_end    = apb.PREADY | timeout_hit;
  // Aborted reads return zero.
  assign rd_val      = apb.PREADY ? apb.PRDATA : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (elig0 | elig1) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output; bus address/data and rdata hold
  // unless explicitly updated.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_d   = pick;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = pick ? wr1    : wr0;
          paddr_d   = pick ? addr1  : addr0;
          pwdata_d  = pick ? wdata1 : wdata0;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (xfer_end) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          last_grant_d = grant_q;
          if (grant_q) begin
            done1_d = 1'b1;
            err1_d  = timeout_hit;
            if (!pwrite_q) rdata1_d = rd_val;
          end else begin
            done0_d = 1'b1;
            err0_d  = timeout_hit;
            if (!pwrite_q) rdata0_d = rd_val;
          end
        end else begin
          // Abort happens at CNT_LAST, so the increment never wraps.
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign err0        = err0_q;
  assign err1        = err1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master (TIMEOUT = 4): directed scenarios
// followed by a randomized phase checked against a transaction-level model.
module tb_apb_arb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic [1:0]    req, wr;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [1:0]    done, err;
  logic [DW-1:0] rdata [2];

  apb_arb_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req0    (req[0]),
    .req1    (req[1]),
    .wr0     (wr[0]),
    .wr1     (wr[1]),
    .addr0   (addr[0]),
    .addr1   (addr[1]),
    .wdata0  (wdata[0]),
    .wdata1  (wdata[1]),
    .done0   (done[0]),
    .done1   (done[1]),
    .err0    (err[0]),
    .err1    (err[1]),
    .rdata0  (rdata[0]),
    .rdata1  (rdata[1]),
    .apb     (apb)
  );

  always #5 PCLK = ~PCLK;

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_rdata [2];
  int            last_g;

  int            g, in_xfer, cur_g, s_cyc, w_rnd, acc_k, ndone, exp_g, lat;
  logic [1:0]    prev_done;
  logic          prev_psel, pend0, pend1;
  logic [DW-1:0] rd_cur;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    PRESETn    = 1'b0;
    req        = '0;
    apb.PREADY = 1'b0;
    repeat (2) tick();
    PRESETn      = 1'b1;
    last_g       = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  // One isolated transfer from requester p with a given number of PREADY-low
  // ACCESS cycles; checks bus phases, done timing, err and rdata.
  task automatic run_single(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                            input int waits);
    int   dt;
    logic exp_err;
    dt      = 3 + ((waits < TO - 1) ? waits : TO - 1);
    exp_err = (waits >= TO);
    wr[p] = w; addr[p] = a; wdata[p] = wd; req[p] = 1'b1;
    apb.PRDATA = rd;
    apb.PREADY = 1'b0;
    for (int k = 1; k <= dt; k++) begin
      tick();
      if (k == 1) begin
        chk("setup_psel", apb.PSEL, 1);
        chk("setup_penable", apb.PENABLE, 0);
        chk("setup_paddr", apb.PADDR, a);
        chk("setup_pwrite", apb.PWRITE, w);
        if (w) chk("setup_pwdata", apb.PWDATA, wd);
      end else if (k < dt) begin
        chk("access_psel", apb.PSEL, 1);
        chk("access_penable", apb.PENABLE, 1);
      end
      if (k < dt) chk("early_done", done, 0);
      apb.PREADY = (k >= 2) && (k - 2 == waits);
      if (k == dt) begin
        if (!w) exp_rdata[p] = exp_err ? '0 : rd;
        last_g = p;
        chk("done_port", done, (p == 0) ? 2'd1 : 2'd2);
        chk("err_port", err, exp_err ? ((p == 0) ? 2'd1 : 2'd2) : 2'd0);
        chk("rdata0", rdata[0], exp_rdata[0]);
        chk("rdata1", rdata[1], exp_rdata[1]);
        chk("end_psel", apb.PSEL, 0);
        chk("end_penable", apb.PENABLE, 0);
        req[p]     = 1'b0;
        apb.PREADY = 1'b0;
      end
    end
    tick();
    chk("done_pulse", done, 0);
    chk("err_pulse", err, 0);
  endtask

  initial begin
    PRESETn = 1'b0;
    req = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    apb.PREADY = 1'b0; apb.PRDATA = '0;
    repeat (2) tick();
    chk("rst_psel", apb.PSEL, 0);
    chk("rst_penable", apb.PENABLE, 0);
    chk("rst_pwrite", apb.PWRITE, 0);
    chk("rst_paddr", apb.PADDR, 0);
    chk("rst_pwdata", apb.PWDATA, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata0", rdata[0], 0);
    chk("rst_rdata1", rdata[1], 0);
    PRESETn = 1'b1;
    last_g = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;

    // Single write, single read with two wait states.
    run_single(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    run_single(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2);

    // Simultaneous held requests alternate 0,1,0,1.
    do_reset();
    wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h11111111;
    wr[1] = 1'b0; addr[1] = 32'h30; wdata[1] = 32'h0;
    req = 2'b11;
    apb.PREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      apb.PRDATA = 32'hA5000000 + i;
      tick();
      chk("rr_setup_psel", apb.PSEL, 1);
      chk("rr_setup_penable", apb.PENABLE, 0);
      chk("rr_paddr", apb.PADDR, g ? 32'h30 : 32'h20);
      tick();
      chk("rr_access", apb.PENABLE, 1);
      tick();
      chk("rr_done", done, g ? 2'd2 : 2'd1);
      chk("rr_gap_psel", apb.PSEL, 0);
      if (g == 1) exp_rdata[1] = apb.PRDATA;
      chk("rr_rdata0", rdata[0], exp_rdata[0]);
      chk("rr_rdata1", rdata[1], exp_rdata[1]);
      if (i == 3) req = 2'b00;
    end
    tick();
    chk("rr_idle", apb.PSEL, 0);
    apb.PREADY = 1'b0;

    // Timeout forces rdata to zero; the other requester then works normally.
    do_reset();
    run_single(0, 1'b0, 32'h44, 32'h0, 32'h12345678, 0);
    run_single(0, 1'b0, 32'h40, 32'h0, 32'hFFFFFFFF, TO);
    run_single(1, 1'b1, 32'h50, 32'h55AA55AA, 32'h0, 1);

    // Reset in ACCESS with PREADY low.
    do_reset();
    wr[0] = 1'b0; addr[0] = 32'h60; req[0] = 1'b1;
    apb.PREADY = 1'b0;
    tick();
    chk("mrst_setup", apb.PSEL, 1);
    tick();
    chk("mrst_access", apb.PENABLE, 1);
    PRESETn = 1'b0;
    #1;
    chk("mrst_psel_async", apb.PSEL, 0);
    chk("mrst_penable_async", apb.PENABLE, 0);
    tick();
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    PRESETn = 1'b1;
    last_g = 1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    tick();
    chk("mrst_fresh_psel", apb.PSEL, 1);
    chk("mrst_fresh_penable", apb.PENABLE, 0);
    chk("mrst_fresh_paddr", apb.PADDR, 32'h60);
    apb.PREADY = 1'b1; apb.PRDATA = 32'hCAFEF00D;
    tick();
    chk("mrst_fresh_access", apb.PENABLE, 1);
    tick();
    chk("mrst_fresh_done", done, 2'd1);
    exp_rdata[0] = 32'hCAFEF00D;
    chk("mrst_fresh_rdata0", rdata[0], exp_rdata[0]);
    req[0] = 1'b0;
    tick();

    // Requester 0 re-requests right after done0 while requester 1 waits.
    wr[0] = 1'b1; addr[0] = 32'h70; wdata[0] = 32'h70707070; req[0] = 1'b1;
    tick();
    chk("rereq_first_paddr", apb.PADDR, 32'h70);
    wr[1] = 1'b0; addr[1] = 32'h80; req[1] = 1'b1; apb.PRDATA = 32'h80808080;
    tick();
    tick();
    chk("rereq_done0", done, 2'd1);
    addr[0] = 32'h74; wdata[0] = 32'h74747474;
    tick();
    chk("rereq_grant1_psel", apb.PSEL, 1);
    chk("rereq_grant1_paddr", apb.PADDR, 32'h80);
    chk("rereq_grant1_pwrite", apb.PWRITE, 0);
    tick();
    tick();
    chk("rereq_done1", done, 2'd2);
    exp_rdata[1] = 32'h80808080;
    chk("rereq_rdata1", rdata[1], exp_rdata[1]);
    req[1] = 1'b0;
    tick();
    chk("rereq_grant0_paddr", apb.PADDR, 32'h74);
    chk("rereq_grant0_pwdata", apb.PWDATA, 32'h74747474);
    tick();
    tick();
    chk("rereq_done0b", done, 2'd1);
    req[0] = 1'b0;
    apb.PREADY = 1'b0;
    tick();

    // Randomized traffic against a transaction-level model.
    do_reset();
    in_xfer = 0; ndone = 0; prev_done = '0; prev_psel = 1'b0;
    cur_g = 0; s_cyc = 0; w_rnd = 0; acc_k = 0; rd_cur = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      chk("rnd_penable_without_psel", apb.PENABLE & ~apb.PSEL, 0);
      if (prev_done != 2'b00)
        chk("rnd_next_grant", apb.PSEL, prev_done[0] ? req[1] : req[0]);
      if (apb.PSEL && !apb.PENABLE) begin
        pend0 = req[0] & ~prev_done[0];
        pend1 = req[1] & ~prev_done[1];
        exp_g = (pend0 && pend1) ? 1 - last_g : (pend0 ? 0 : 1);
        chk("rnd_pending", (pend0 | pend1), 1);
        chk("rnd_overlap", in_xfer, 0);
        chk("rnd_turnaround", prev_psel, 0);
        chk("rnd_paddr", apb.PADDR, addr[exp_g]);
        chk("rnd_pwrite", apb.PWRITE, wr[exp_g]);
        if (wr[exp_g]) chk("rnd_pwdata", apb.PWDATA, wdata[exp_g]);
        in_xfer = 1; cur_g = exp_g; s_cyc = cyc; acc_k = 0;
        w_rnd = $urandom_range(0, TO + 1);
        rd_cur = $urandom;
        apb.PRDATA = rd_cur;
      end
      if (done != 2'b00) begin
        chk("rnd_done_expected", in_xfer, 1);
        chk("rnd_done_port", done, cur_g ? 2'd2 : 2'd1);
        lat = 2 + ((w_rnd < TO - 1) ? w_rnd : TO - 1);
        chk("rnd_latency", cyc - s_cyc, lat);
        chk("rnd_err", err, (w_rnd >= TO) ? (cur_g ? 2'd2 : 2'd1) : 2'd0);
        if (!wr[cur_g]) exp_rdata[cur_g] = (w_rnd >= TO) ? '0 : rd_cur;
        last_g = cur_g; in_xfer = 0; ndone++;
        req[cur_g]   = 1'($urandom_range(0, 1));
        wr[cur_g]    = 1'($urandom_range(0, 1));
        addr[cur_g]  = $urandom;
        wdata[cur_g] = $urandom;
      end else begin
        chk("rnd_err_idle", err, 0);
      end
      chk("rnd_rdata0", rdata[0], exp_rdata[0]);
      chk("rnd_rdata1", rdata[1], exp_rdata[1]);
      if (in_xfer != 0) chk("rnd_watchdog", (cyc - s_cyc) <= TO + 4, 1);
      if (apb.PSEL && apb.PENABLE) begin
        apb.PREADY = (acc_k == w_rnd);
        acc_k++;
      end else begin
        apb.PREADY = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 2; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i]   = 1'b1;
          wr[i]    = 1'($urandom_range(0, 1));
          addr[i]  = $urandom;
          wdata[i] = $urandom;
        end
      end
      prev_done = done;
      prev_psel = apb.PSEL;
    end
    chk("rnd_progress", ndone > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
